// File: rtl/freq_meter_pkg.sv
// Shared types and default widths for the multi-channel frequency meter.
`timescale 1ns/1ps
package freq_meter_pkg;

  localparam int FM_NB_CH        = 4;
  localparam int FM_CNT_WIDTH    = 16;
  localparam int FM_WIN_WIDTH    = 20;
  localparam int FM_REF_FREQ_KHZ = 100000;

  typedef enum logic {
    FM_IDLE,
    FM_MEAS
  } fm_state_e;

  typedef logic [FM_NB_CH-1:0][FM_CNT_WIDTH-1:0] fm_count_arr_t;

endpackage

// File: rtl/freq_meter_sync_edge.sv
// Three-flop synchronizer for one asynchronous measured input, plus rising-edge detect.
`timescale 1ns/1ps
module freq_meter_sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic meas_clk,
  output logic rise
);

  logic s1, s2, s3;

  // NOTE: sequential state uses non-blocking assignments so the chain shifts by one stage per clock.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= meas_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/freq_meter_mc.sv
// Multi-channel frequency meter: counts input edges over a programmable window of clk cycles.
// Optional simulation-only result log enabled by defining FREQ_METER_MC_LOG_EN.
`timescale 1ns/1ps
module freq_meter_mc
  import freq_meter_pkg::*;
#(
  parameter int NB_CH        = FM_NB_CH,
  parameter int CNT_WIDTH    = FM_CNT_WIDTH,
  parameter int WIN_WIDTH    = FM_WIN_WIDTH,
  parameter int REF_FREQ_KHZ = FM_REF_FREQ_KHZ
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NB_CH-1:0]           meas_clk_i,
  input  logic [WIN_WIDTH-1:0]       win_len_i,
  input  logic                       start_i,
  input  logic                       cont_i,
  input  logic                       stop_i,
  output logic                       busy_o,
  output logic                       valid_o,
  output logic [NB_CH*CNT_WIDTH-1:0] count_o,
  output logic [NB_CH-1:0]           ovf_o
);

  localparam logic [WIN_WIDTH-1:0] WIN_ONE = WIN_WIDTH'(1);

  if (REF_FREQ_KHZ <= 0 || NB_CH < 1) begin : g_param_check
    $error("freq_meter_mc: REF_FREQ_KHZ and NB_CH must be positive");
  end

  fm_state_e                         state;
  logic                              arm_q;
  logic [WIN_WIDTH-1:0]              win_cnt;
  logic [WIN_WIDTH-1:0]              win_load;
  logic [NB_CH-1:0]                  rise;
  logic [NB_CH-1:0][CNT_WIDTH-1:0]   cnt_q, cnt_nxt;
  logic [NB_CH-1:0]                  ovf_q, ovf_nxt;

  for (genvar i = 0; i < NB_CH; i++) begin : g_ch
    freq_meter_sync_edge u_sync (
      .clk      (clk),
      .rstn     (rstn),
      .meas_clk (meas_clk_i[i]),
      .rise     (rise[i])
    );
  end

  assign win_load = (win_len_i == '0) ? WIN_ONE : win_len_i;

  // NOTE: every combinational output gets a default first, so no latch is inferred.
  always_comb begin
    cnt_nxt = cnt_q;
    ovf_nxt = ovf_q;
    for (int i = 0; i < NB_CH; i++) begin
      if (rise[i]) begin
        if (&cnt_q[i]) ovf_nxt[i] = 1'b1;
        else           cnt_nxt[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // arm_q spends the cycle after start idle, so the first window ends at start+N+1
  // while back-to-back continuous windows stay exactly N cycles apart.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= FM_IDLE;
      arm_q   <= 1'b0;
      win_cnt <= '0;
      cnt_q   <= '0;
      ovf_q   <= '0;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
      count_o <= '0;
      ovf_o   <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        FM_IDLE: begin
          if (start_i && !stop_i) begin
            state   <= FM_MEAS;
            busy_o  <= 1'b1;
            arm_q   <= 1'b1;
            win_cnt <= win_load;
            cnt_q   <= '0;
            ovf_q   <= '0;
          end
        end
        FM_MEAS: begin
          if (stop_i) begin
            state  <= FM_IDLE;
            busy_o <= 1'b0;
            arm_q  <= 1'b0;
          end else if (arm_q) begin
            arm_q <= 1'b0;
          end else if (win_cnt == WIN_ONE) begin
            count_o <= cnt_nxt;
            ovf_o   <= ovf_nxt;
            valid_o <= 1'b1;
            cnt_q   <= '0;
            ovf_q   <= '0;
            if (cont_i) begin
              win_cnt <= win_load;
            end else begin
              state  <= FM_IDLE;
              busy_o <= 1'b0;
            end
          end else begin
            win_cnt <= win_cnt - 1'b1;
            cnt_q   <= cnt_nxt;
            ovf_q   <= ovf_nxt;
          end
        end
        default: state <= FM_IDLE;
      endcase
    end
  end

`ifdef FREQ_METER_MC_LOG_EN
  // Simulation-only: remember the length of the window being reported alongside each result.
  logic [WIN_WIDTH-1:0] cur_win, done_win;

  always @(posedge clk) begin
    if (state == FM_IDLE && start_i && !stop_i) cur_win <= win_load;
    if (state == FM_MEAS && !stop_i && !arm_q && win_cnt == WIN_ONE) begin
      done_win <= cur_win;
      if (cont_i) cur_win <= win_load;
    end
  end

  always @(negedge clk) begin
    if (valid_o) begin
      for (int i = 0; i < NB_CH; i++) begin
        $display("ch %0d count %0d ovf %0d freq_mhz %f time %0t", i,
                 count_o[i*CNT_WIDTH +: CNT_WIDTH], ovf_o[i],
                 real'(count_o[i*CNT_WIDTH +: CNT_WIDTH]) * real'(REF_FREQ_KHZ)
                   / (real'(done_win) * 1000.0), $time);
      end
    end
  end
`endif

endmodule

// File: tb/tb_freq_meter_mc.sv
// Self-checking bench for freq_meter_mc: timestamped input edges against an interval-count model.
`timescale 1ns/1ps
module tb_freq_meter_mc;

  localparam int NB      = 4;
  localparam int CW      = 8;
  localparam int WW      = 20;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NB-1:0]     meas_clk;
  logic [WW-1:0]     win_len = '0;
  logic              start = 1'b0, cont = 1'b0, stop = 1'b0;
  logic              busy, valid;
  logic [NB*CW-1:0]  count;
  logic [NB-1:0]     ovf;

  int  errors = 0;
  int  checks = 0;

  real half [NB] = '{0.0, 0.0, 0.0, 0.0};
  real rise_q [NB][$];
  real edge_q [$];

  typedef struct {
    int               cyc;
    logic [NB*CW-1:0] cnt;
    logic [NB-1:0]    ovf;
  } vrec_t;
  vrec_t vq [$];

  int exp_cnt [NB];
  bit exp_ovf [NB];

  freq_meter_mc #(
    .NB_CH(NB), .CNT_WIDTH(CW), .WIN_WIDTH(WW), .REF_FREQ_KHZ(100000)
  ) dut (
    .clk(clk), .rstn(rstn), .meas_clk_i(meas_clk), .win_len_i(win_len),
    .start_i(start), .cont_i(cont), .stop_i(stop),
    .busy_o(busy), .valid_o(valid), .count_o(count), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  // Measured sources: edges sit at x.37/x.87 ns, never on a clk edge.
  for (genvar g = 0; g < NB; g++) begin : g_src
    logic v = 1'b0;
    initial begin
      #0.37;
      forever begin
        if (half[g] == 0.0) begin
          v = 1'b0;
          #10;
        end else begin
          #(half[g]) v = ~v;
        end
      end
    end
    assign meas_clk[g] = v;
    always @(posedge v) rise_q[g].push_back($realtime);
  end

  always @(posedge clk) edge_q.push_back($realtime);

  always @(posedge clk) begin
    #1;
    if (valid === 1'b1) vq.push_back('{edge_q.size() - 1, count, ovf});
  end

  // Input rises first sampled at clk edges a..b inclusive: those in (T[a-1], T[b]].
  function automatic int model_rises(input int ch, input int a, input int b);
    real lo, hi;
    int  n;
    n  = 0;
    lo = (a > 0) ? edge_q[a-1] : -1.0;
    hi = edge_q[b];
    for (int i = 0; i < rise_q[ch].size(); i++)
      if (rise_q[ch][i] > lo && rise_q[ch][i] <= hi) n++;
    return n;
  endfunction

  task automatic model_window(input int a, input int n);
    int r;
    for (int ch = 0; ch < NB; ch++) begin
      r = model_rises(ch, a, a + n - 1);
      exp_cnt[ch] = (r > CNT_MAX) ? CNT_MAX : r;
      exp_ovf[ch] = (r > CNT_MAX);
    end
  endtask

  function automatic logic [NB*CW-1:0] exp_cnt_vec();
    logic [NB*CW-1:0] v;
    for (int ch = 0; ch < NB; ch++) v[ch*CW +: CW] = CW'(exp_cnt[ch]);
    return v;
  endfunction

  function automatic logic [NB-1:0] exp_ovf_vec();
    logic [NB-1:0] v;
    for (int ch = 0; ch < NB; ch++) v[ch] = exp_ovf[ch];
    return v;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_meas(input int len, output int t);
    @(negedge clk);
    win_len = WW'(len);
    start   = 1'b1;
    t       = edge_q.size();
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_valids(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (vq.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    cycles(3);
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (count !== '0)   begin errors++; $display("FAIL reset_count: got %h want 0", count); end
    checks++; if (ovf !== '0)     begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    rstn = 1'b1;
    cycles(5);
    checks++; if (busy !== 1'b0 || vq.size() != 0) begin
      errors++; $display("FAIL reset_idle: busy=%b valids=%0d want 0/0", busy, vq.size());
    end
  endtask

  task automatic test_basic();
    int t;
    bit ok;
    half[0] = 50.0; half[1] = 20.0; half[2] = 0.0; half[3] = 500.0;
    cont = 1'b0;
    vq.delete();
    @(negedge clk);
    win_len = WW'(1000);
    start   = 1'b1;
    t       = edge_q.size();
    cycles(3);
    start   = 1'b0;
    wait_valids(1, 1100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got no valid want one"); end
    if (ok) begin
      model_window(t, 1000);
      checks++; if (vq[0].cyc != t + 1001) begin
        errors++; $display("FAIL basic_latency: got edge %0d want %0d", vq[0].cyc, t + 1001);
      end
      for (int ch = 0; ch < NB; ch++) begin
        checks++;
        if (vq[0].cnt[ch*CW +: CW] !== CW'(exp_cnt[ch]) || vq[0].ovf[ch] !== exp_ovf[ch]) begin
          errors++;
          $display("FAIL basic_ch%0d: got count=%0d ovf=%b want count=%0d ovf=%b", ch,
                   vq[0].cnt[ch*CW +: CW], vq[0].ovf[ch], exp_cnt[ch], exp_ovf[ch]);
        end
      end
      checks++; if (vq[0].cnt[CW +: CW] < 249 || vq[0].cnt[CW +: CW] > 251) begin
        errors++; $display("FAIL basic_nominal_ch1: got %0d want 250+-1", vq[0].cnt[CW +: CW]);
      end
    end
    cycles(5);
    checks++; if (busy !== 1'b0 || vq.size() != 1) begin
      errors++; $display("FAIL basic_after: busy=%b valids=%0d want 0/1", busy, vq.size());
    end
  endtask

  task automatic test_continuous();
    int t;
    bit ok;
    half[0] = 25.0;
    cont = 1'b1;
    vq.delete();
    start_meas(500, t);
    wait_valids(3, 1600, ok);
    cont = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL cont_timeout: got %0d valids want 3", vq.size()); end
    wait_valids(4, 600, ok);
    cycles(600);
    checks++; if (vq.size() != 4 || busy !== 1'b0) begin
      errors++; $display("FAIL cont_stop: valids=%0d busy=%b want 4/0", vq.size(), busy);
    end
    for (int j = 0; j < 4 && j < vq.size(); j++) begin
      model_window(t + j * 500, 500);
      checks++; if (vq[j].cyc != t + (j + 1) * 500 + 1) begin
        errors++; $display("FAIL cont_period%0d: got edge %0d want %0d", j, vq[j].cyc, t + (j + 1) * 500 + 1);
      end
      checks++; if (vq[j].cnt !== exp_cnt_vec() || vq[j].ovf !== exp_ovf_vec()) begin
        errors++; $display("FAIL cont_counts%0d: got %h/%b want %h/%b", j, vq[j].cnt, vq[j].ovf,
                           exp_cnt_vec(), exp_ovf_vec());
      end
    end
  endtask

  task automatic test_saturation();
    int t;
    bit ok;
    half[0] = 12.5;
    foreach (win_len[i]) ;
    for (int pass = 0; pass < 2; pass++) begin
      vq.delete();
      start_meas((pass == 0) ? 1000 : 500, t);
      wait_valids(1, 1100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL sat_timeout%0d: got no valid want one", pass); end
      if (ok) begin
        model_window(t, (pass == 0) ? 1000 : 500);
        checks++; if (vq[0].cnt[CW-1:0] !== CW'(exp_cnt[0]) || vq[0].ovf[0] !== exp_ovf[0]) begin
          errors++; $display("FAIL sat_ch0_%0d: got count=%0d ovf=%b want count=%0d ovf=%b", pass,
                             vq[0].cnt[CW-1:0], vq[0].ovf[0], exp_cnt[0], exp_ovf[0]);
        end
        checks++; if (vq[0].ovf[0] !== (pass == 0)) begin
          errors++; $display("FAIL sat_flag%0d: got ovf=%b want %0d", pass, vq[0].ovf[0], pass == 0);
        end
      end
    end
  endtask

  task automatic test_abort();
    vq.delete();
    @(negedge clk);
    win_len = WW'(1000);
    start   = 1'b1;
    cycles(200);
    start   = 1'b0;
    cycles(99);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    cycles(1100);
    checks++; if (vq.size() != 0) begin errors++; $display("FAIL abort_valid: got %0d valids want 0", vq.size()); end
    checks++; if (count !== exp_cnt_vec() || ovf !== exp_ovf_vec()) begin
      errors++; $display("FAIL abort_hold: got %h/%b want %h/%b", count, ovf, exp_cnt_vec(), exp_ovf_vec());
    end
  endtask

  task automatic test_reset_mid();
    int t;
    vq.delete();
    start_meas(1000, t);
    cycles(398);
    rstn = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || valid !== 1'b0 || count !== '0 || ovf !== '0) begin
      errors++; $display("FAIL midreset_outputs: busy=%b valid=%b count=%h ovf=%b want all 0",
                         busy, valid, count, ovf);
    end
    rstn = 1'b1;
    cycles(1100);
    checks++; if (busy !== 1'b0 || vq.size() != 0) begin
      errors++; $display("FAIL midreset_idle: busy=%b valids=%0d want 0/0", busy, vq.size());
    end
    for (int ch = 0; ch < NB; ch++) begin
      exp_cnt[ch] = 0;
      exp_ovf[ch] = 1'b0;
    end
  endtask

  task automatic test_edge_cases();
    int t;
    bit ok;
    half[0] = 11.0; half[1] = 11.5; half[2] = 30.0; half[3] = 12.5;
    vq.delete();
    start_meas(0, t);
    wait_valids(1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL len0_timeout: got no valid want one"); end
    if (ok) begin
      model_window(t, 1);
      checks++; if (vq[0].cyc != t + 2) begin
        errors++; $display("FAIL len0_latency: got edge %0d want %0d", vq[0].cyc, t + 2);
      end
      checks++; if (vq[0].cnt !== exp_cnt_vec() || vq[0].ovf !== exp_ovf_vec()) begin
        errors++; $display("FAIL len0_counts: got %h/%b want %h/%b", vq[0].cnt, vq[0].ovf,
                           exp_cnt_vec(), exp_ovf_vec());
      end
    end
    cycles(3);
    vq.delete();
    start_meas(20, t);
    cycles(20);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    cycles(30);
    checks++; if (vq.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL stop_at_end: valids=%0d busy=%b want 0/0", vq.size(), busy);
    end
    checks++; if (count !== exp_cnt_vec() || ovf !== exp_ovf_vec()) begin
      errors++; $display("FAIL stop_at_end_hold: got %h/%b want %h/%b", count, ovf, exp_cnt_vec(), exp_ovf_vec());
    end
  endtask

  task automatic test_random();
    int t, n;
    bit ok;
    for (int it = 0; it < 4; it++) begin
      for (int ch = 0; ch < NB; ch++) half[ch] = real'($urandom_range(22, 600)) / 2.0;
      n = $urandom_range(1, 1500);
      vq.delete();
      start_meas(n, t);
      wait_valids(1, n + 20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_timeout: got no valid want one (N=%0d)", it, n); end
      if (ok) begin
        model_window(t, n);
        checks++; if (vq[0].cyc != t + n + 1) begin
          errors++; $display("FAIL rand%0d_latency: got edge %0d want %0d", it, vq[0].cyc, t + n + 1);
        end
        checks++; if (vq[0].cnt !== exp_cnt_vec() || vq[0].ovf !== exp_ovf_vec()) begin
          errors++; $display("FAIL rand%0d_counts: got %h/%b want %h/%b (N=%0d)", it, vq[0].cnt,
                             vq[0].ovf, exp_cnt_vec(), exp_ovf_vec(), n);
        end
      end
      cycles(3);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_continuous();
    test_saturation();
    test_abort();
    test_reset_mid();
    test_edge_cases();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
